// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, issues single-outstanding word fetches,
// and holds the returned instruction for decode until it is consumed or flushed.
module fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    output logic [31:0] instr_pc4,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic        fetch_err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        HOLD = 2'd2,
        ERR  = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        kill_q, kill_d;
    logic        err_pend_q, err_pend_d;
    logic        req_q, req_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] instr_pc_q, instr_pc_d;
    logic [31:0] instr_pc4_q, instr_pc4_d;
    logic        valid_q, valid_d;
    logic        err_q, err_d;

    logic        redir_mis;
    logic [31:0] drop_pc;
    logic        drop_bad;

    assign redir_mis = (redirect_pc[1:0] != 2'b00);
    // On a dropped ack, a same-cycle redirect is the latest one and overrides any pending target.
    assign drop_pc   = redirect_valid ? redirect_pc : pc_q;
    assign drop_bad  = redirect_valid ? redir_mis : err_pend_q;

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        kill_d      = kill_q;
        err_pend_d  = err_pend_q;
        req_d       = req_q;
        addr_d      = addr_q;
        instr_d     = instr_q;
        instr_pc_d  = instr_pc_q;
        instr_pc4_d = instr_pc4_q;
        valid_d     = valid_q;
        err_d       = err_q;

        case (state_q)
            IDLE: begin
                state_d = REQ;
                req_d   = 1'b1;
                addr_d  = {pc_q[31:2], 2'b00};
            end

            REQ: begin
                if (imem_ack) begin
                    if (kill_q || redirect_valid) begin
                        kill_d     = 1'b0;
                        err_pend_d = 1'b0;
                        pc_d       = drop_pc;
                        if (drop_bad) begin
                            state_d = ERR;
                            req_d   = 1'b0;
                            err_d   = 1'b1;
                        end else begin
                            state_d = REQ;
                            req_d   = 1'b1;
                            addr_d  = drop_pc;
                        end
                    end else begin
                        state_d     = HOLD;
                        req_d       = 1'b0;
                        instr_d     = imem_rdata;
                        instr_pc_d  = addr_q;
                        instr_pc4_d = addr_q + 32'd4;
                        valid_d     = 1'b1;
                        pc_d        = addr_q + 32'd4;
                    end
                end else if (redirect_valid) begin
                    // Address stays put until the memory accepts; the ack is then discarded.
                    pc_d       = redirect_pc;
                    kill_d     = 1'b1;
                    err_pend_d = redir_mis;
                end
            end

            HOLD: begin
                if (redirect_valid) begin
                    valid_d = 1'b0;
                    instr_d = NOP_INSTR;
                    pc_d    = redirect_pc;
                    if (redir_mis) begin
                        state_d = ERR;
                        err_d   = 1'b1;
                    end else begin
                        state_d = REQ;
                        req_d   = 1'b1;
                        addr_d  = redirect_pc;
                    end
                end else if (instr_ready) begin
                    valid_d = 1'b0;
                    instr_d = NOP_INSTR;
                    state_d = REQ;
                    req_d   = 1'b1;
                    addr_d  = pc_q;
                end
            end

            ERR: begin
                req_d   = 1'b0;
                valid_d = 1'b0;
                instr_d = NOP_INSTR;
                err_d   = 1'b1;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            pc_q        <= RESET_PC;
            kill_q      <= 1'b0;
            err_pend_q  <= 1'b0;
            req_q       <= 1'b0;
            addr_q      <= RESET_PC;
            instr_q     <= NOP_INSTR;
            instr_pc_q  <= RESET_PC;
            instr_pc4_q <= RESET_PC + 32'd4;
            valid_q     <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            kill_q      <= kill_d;
            err_pend_q  <= err_pend_d;
            req_q       <= req_d;
            addr_q      <= addr_d;
            instr_q     <= instr_d;
            instr_pc_q  <= instr_pc_d;
            instr_pc4_q <= instr_pc4_d;
            valid_q     <= valid_d;
            err_q       <= err_d;
        end
    end

    assign imem_req    = req_q;
    assign imem_addr   = addr_q;
    assign instr       = instr_q;
    assign instr_pc    = instr_pc_q;
    assign instr_pc4   = instr_pc4_q;
    assign instr_valid = valid_q;
    assign fetch_err   = err_q;

endmodule
